// File: rtl/traffic_light_ctrl_n_if.sv
// Signal bundle between the N-approach light sequencer and its environment.
// The master side drives detectors, timing enable and pre-emption; the slave is the controller.
interface traffic_light_ctrl_n_if #(
  parameter int unsigned NUM_DIR = 4,
  parameter int unsigned DIR_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
);
  logic                 tick_en;
  logic [NUM_DIR-1:0]   veh_req;
  logic                 emerg_req;
  logic [DIR_W-1:0]     emerg_dir;
  logic [2*NUM_DIR-1:0] lights;
  logic [1:0]           phase;
  logic [DIR_W-1:0]     active_dir;
  logic                 emerg_active;

  modport master (
    output tick_en, veh_req, emerg_req, emerg_dir,
    input  lights, phase, active_dir, emerg_active
  );

  modport slave (
    input  tick_en, veh_req, emerg_req, emerg_dir,
    output lights, phase, active_dir, emerg_active
  );
endinterface

// File: rtl/traffic_light_ctrl_n.sv
// Round-robin N-approach traffic light sequencer with demand skipping, rest-on-green,
// all-red clearance between greens and emergency pre-emption, timed in tick_en pulses.
module traffic_light_ctrl_n #(
  parameter int unsigned NUM_DIR      = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_TICKS  = 16,
  parameter int unsigned YELLOW_TICKS = 5,
  parameter int unsigned ALLRED_TICKS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_light_ctrl_n_if.slave  bus
);

  localparam int unsigned DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [DIR_W-1:0]   active_dir_q, active_dir_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [NUM_DIR-1:0] pending_q, pending_d;

  logic               emerg_valid;
  logic               emerg_match;
  logic [CNT_W-1:0]   dur_last;
  logic               expire;
  logic [NUM_DIR-1:0] others;
  logic               other_pend;
  logic [DIR_W-1:0]   inc_dir;
  logic [DIR_W-1:0]   scan_dir;
  logic               scan_found;
  logic [DIR_W-1:0]   target_dir;
  int unsigned        idx;
  logic [DIR_W-1:0]   cand;
  logic [2*NUM_DIR-1:0] lights;

  assign emerg_valid = bus.emerg_req && (32'(bus.emerg_dir) < NUM_DIR);
  assign emerg_match = (bus.emerg_dir == active_dir_q);
  assign inc_dir     = (active_dir_q == LAST_DIR) ? '0 : active_dir_q + 1'b1;

  always_comb begin
    dur_last = ALLRED_LAST;
    case (phase_q)
      PH_GREEN:  dur_last = GREEN_LAST;
      PH_YELLOW: dur_last = YELLOW_LAST;
      default:   dur_last = ALLRED_LAST;
    endcase
  end

  assign expire = bus.tick_en && (counter_q == dur_last);

  always_comb begin
    others               = pending_q;
    others[active_dir_q] = 1'b0;
    other_pend           = |others;
  end

  // Scan starts one past the current approach; the current one is checked last.
  always_comb begin
    scan_found = 1'b0;
    scan_dir   = inc_dir;
    idx        = 0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_DIR; k++) begin
      idx = 32'(active_dir_q) + k;
      if (idx >= NUM_DIR) idx = idx - NUM_DIR;
      cand = DIR_W'(idx);
      if (!scan_found && pending_q[cand]) begin
        scan_found = 1'b1;
        scan_dir   = cand;
      end
    end
  end

  always_comb begin
    if (emerg_valid)     target_dir = bus.emerg_dir;
    else if (scan_found) target_dir = scan_dir;
    else                 target_dir = inc_dir;
  end

  always_comb begin
    phase_d      = phase_q;
    active_dir_d = active_dir_q;
    counter_d    = counter_q;
    pending_d    = pending_q | bus.veh_req;
    if (phase_q == PH_GREEN) pending_d[active_dir_q] = pending_q[active_dir_q];

    case (phase_q)
      PH_GREEN: begin
        if (emerg_valid && !emerg_match) begin
          phase_d   = PH_YELLOW;
          counter_d = '0;
        end else if (emerg_valid) begin
          counter_d = '0;
        end else if (expire) begin
          counter_d = '0;
          if (other_pend) phase_d = PH_YELLOW;
        end else if (bus.tick_en) begin
          counter_d = counter_q + 1'b1;
        end
      end
      PH_YELLOW: begin
        if (expire) begin
          phase_d   = PH_ALLRED;
          counter_d = '0;
        end else if (bus.tick_en) begin
          counter_d = counter_q + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (expire) begin
          phase_d               = PH_GREEN;
          active_dir_d          = target_dir;
          counter_d             = '0;
          pending_d[target_dir] = 1'b0;
        end else if (bus.tick_en) begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        phase_d   = PH_ALLRED;
        counter_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_ALLRED;
      active_dir_q <= LAST_DIR;
      counter_q    <= '0;
      pending_q    <= '0;
    end else begin
      phase_q      <= phase_d;
      active_dir_q <= active_dir_d;
      counter_q    <= counter_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (phase_q != PH_ALLRED && DIR_W'(i) == active_dir_q)
        lights[2*i +: 2] = (phase_q == PH_GREEN) ? 2'b00 : 2'b01;
      else
        lights[2*i +: 2] = 2'b10;
    end
  end

  assign bus.lights       = lights;
  assign bus.phase        = phase_q;
  assign bus.active_dir   = active_dir_q;
  assign bus.emerg_active = (phase_q == PH_GREEN) && emerg_valid && emerg_match;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench for traffic_light_ctrl_n: a 4-approach instance for the main scenarios and
// a 3-approach instance where an out-of-range emergency direction is representable.
module tb_traffic_light_ctrl_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_light_ctrl_n_if #(.NUM_DIR(4)) bus  ();
  traffic_light_ctrl_n_if #(.NUM_DIR(3)) bus3 ();

  traffic_light_ctrl_n #(
    .NUM_DIR(4), .CNT_W(8), .GREEN_TICKS(16), .YELLOW_TICKS(5), .ALLRED_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  traffic_light_ctrl_n #(
    .NUM_DIR(3), .CNT_W(8), .GREEN_TICKS(16), .YELLOW_TICKS(5), .ALLRED_TICKS(2)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int total = 0;
  int bad   = 0;

  // Leaves the bench at the first falling edge after the reset edge, rst already low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.tick_en = 1'b1;  bus.veh_req = '0;  bus.emerg_req = 1'b0;  bus.emerg_dir = '0;
    bus3.tick_en = 1'b1; bus3.veh_req = '0; bus3.emerg_req = 1'b0; bus3.emerg_dir = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_l;
    logic [1:0] exp_p;
    logic [1:0] exp_d;
    do_reset();
    total++;
    if (dut.pending_q !== 4'b0000) begin
      bad++; $display("FAIL reset_pending got=%b exp=0000", dut.pending_q);
    end
    total++;
    if (dut.counter_q !== 8'd0) begin
      bad++; $display("FAIL reset_counter got=%0d exp=0", dut.counter_q);
    end
    for (int n = 0; n <= 40; n++) begin
      exp_l = (n < 2) ? 8'hAA : 8'hA8;
      exp_p = (n < 2) ? 2'b10 : 2'b00;
      exp_d = (n < 2) ? 2'd3 : 2'd0;
      total++;
      if (bus.lights !== exp_l || bus.phase !== exp_p || bus.active_dir !== exp_d || bus.emerg_active !== 1'b0) begin
        bad++;
        $display("FAIL rest n=%0d got lights=%h phase=%b dir=%0d ea=%b exp lights=%h phase=%b dir=%0d ea=0",
                 n, bus.lights, bus.phase, bus.active_dir, bus.emerg_active, exp_l, exp_p, exp_d);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skip();
    logic [7:0] exp_l;
    do_reset();
    for (int n = 0; n <= 30; n++) begin
      if (n < 2)       exp_l = 8'hAA;
      else if (n < 18) exp_l = 8'hA8;
      else if (n < 23) exp_l = 8'hA9;
      else if (n < 25) exp_l = 8'hAA;
      else             exp_l = 8'h8A;
      total++;
      if (bus.lights !== exp_l) begin
        bad++; $display("FAIL skip n=%0d got=%h exp=%h", n, bus.lights, exp_l);
      end
      if (n == 5) bus.veh_req = 4'b0100;
      if (n == 6) bus.veh_req = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_tick_scaling();
    logic [7:0] exp_l;
    do_reset();
    for (int n = 0; n <= 105; n++) begin
      if (n < 8)        exp_l = 8'hAA;
      else if (n < 72)  exp_l = 8'hA8;
      else if (n < 92)  exp_l = 8'hA9;
      else if (n < 100) exp_l = 8'hAA;
      else              exp_l = 8'h8A;
      total++;
      if (bus.lights !== exp_l) begin
        bad++; $display("FAIL tick_scale n=%0d got=%h exp=%h", n, bus.lights, exp_l);
      end
      bus.tick_en = ((n + 1) % 4 == 0);
      if (n == 10) bus.veh_req = 4'b0100;
      if (n == 11) bus.veh_req = 4'b0000;
      @(negedge clk);
    end
    bus.tick_en = 1'b1;
  endtask

  task automatic test_preempt();
    logic [7:0] exp_l;
    logic       exp_ea;
    do_reset();
    for (int n = 0; n <= 64; n++) begin
      if (n < 2)       exp_l = 8'hAA;
      else if (n < 6)  exp_l = 8'hA8;
      else if (n < 11) exp_l = 8'hA9;
      else if (n < 13) exp_l = 8'hAA;
      else if (n < 56) exp_l = 8'h2A;
      else if (n < 61) exp_l = 8'h6A;
      else if (n < 63) exp_l = 8'hAA;
      else             exp_l = 8'hA2;
      exp_ea = (n >= 13 && n <= 40);
      total++;
      if (bus.lights !== exp_l || bus.emerg_active !== exp_ea) begin
        bad++;
        $display("FAIL preempt n=%0d got lights=%h ea=%b exp lights=%h ea=%b",
                 n, bus.lights, bus.emerg_active, exp_l, exp_ea);
      end
      if (n == 5)  begin bus.emerg_req = 1'b1; bus.emerg_dir = 2'd3; end
      if (n == 20) bus.veh_req = 4'b0010;
      if (n == 21) bus.veh_req = 4'b0000;
      if (n == 40) bus.emerg_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_emerg_active_dir();
    logic [7:0] exp_l;
    logic       exp_ea;
    do_reset();
    for (int n = 0; n <= 50; n++) begin
      if (n < 2)       exp_l = 8'hAA;
      else if (n < 46) exp_l = 8'hA8;
      else             exp_l = 8'hA9;
      exp_ea = (n >= 6 && n <= 30);
      total++;
      if (bus.lights !== exp_l || bus.emerg_active !== exp_ea) begin
        bad++;
        $display("FAIL emerg_same n=%0d got lights=%h ea=%b exp lights=%h ea=%b",
                 n, bus.lights, bus.emerg_active, exp_l, exp_ea);
      end
      if (n >= 6 && n <= 30) begin
        total++;
        if (dut.counter_q !== 8'd0) begin
          bad++; $display("FAIL emerg_hold_cnt n=%0d got=%0d exp=0", n, dut.counter_q);
        end
      end
      if (n >= 31 && n <= 45) begin
        total++;
        if (dut.counter_q !== 8'(n - 30)) begin
          bad++; $display("FAIL emerg_release_cnt n=%0d got=%0d exp=%0d", n, dut.counter_q, n - 30);
        end
      end
      if (n == 3)  bus.veh_req = 4'b0010;
      if (n == 4)  bus.veh_req = 4'b0000;
      if (n == 5)  begin bus.emerg_req = 1'b1; bus.emerg_dir = 2'd0; end
      if (n == 30) bus.emerg_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_emerg_invalid();
    logic [5:0] exp_l;
    do_reset();
    bus3.emerg_req = 1'b1;
    bus3.emerg_dir = 2'd3;
    for (int n = 0; n <= 28; n++) begin
      if (n < 2)       exp_l = 6'h2A;
      else if (n < 18) exp_l = 6'h28;
      else if (n < 23) exp_l = 6'h29;
      else if (n < 25) exp_l = 6'h2A;
      else             exp_l = 6'h22;
      total++;
      if (bus3.lights !== exp_l || bus3.emerg_active !== 1'b0) begin
        bad++;
        $display("FAIL emerg_invalid n=%0d got lights=%h ea=%b exp lights=%h ea=0",
                 n, bus3.lights, bus3.emerg_active, exp_l);
      end
      if (n == 3) bus3.veh_req = 3'b010;
      if (n == 4) bus3.veh_req = 3'b000;
      @(negedge clk);
    end
    bus3.emerg_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n <= 24; n++) begin
      if (n == 19) begin
        total++;
        if (bus.phase !== 2'b01 || dut.pending_q !== 4'b0110) begin
          bad++; $display("FAIL mid_pre n=%0d got phase=%b pend=%b exp phase=01 pend=0110",
                          n, bus.phase, dut.pending_q);
        end
      end
      if (n == 20) begin
        total++;
        if (bus.lights !== 8'hAA || dut.pending_q !== 4'b0000 || bus.active_dir !== 2'd3 ||
            bus.phase !== 2'b10 || dut.counter_q !== 8'd0) begin
          bad++;
          $display("FAIL mid_reset got lights=%h pend=%b dir=%0d phase=%b cnt=%0d exp AA 0000 3 10 0",
                   bus.lights, dut.pending_q, bus.active_dir, bus.phase, dut.counter_q);
        end
      end
      if (n == 21) begin
        total++;
        if (bus.lights !== 8'hAA) begin
          bad++; $display("FAIL mid_allred got=%h exp=aa", bus.lights);
        end
      end
      if (n >= 22) begin
        total++;
        if (bus.lights !== 8'hA8 || bus.active_dir !== 2'd0) begin
          bad++; $display("FAIL mid_green n=%0d got lights=%h dir=%0d exp a8 0", n, bus.lights, bus.active_dir);
        end
      end
      if (n == 3)  bus.veh_req = 4'b0110;
      if (n == 4)  bus.veh_req = 4'b0000;
      if (n == 19) rst = 1'b1;
      if (n == 20) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_skip();
    test_tick_scaling();
    test_preempt();
    test_emerg_active_dir();
    test_emerg_invalid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
